// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap/mret sequencer that owns the trap CSRs and steers mux_privilege.
module trap_controller #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_valid,
   input  logic [31:0] I_pc,
   input  logic        I_exc_illegal,
   input  logic        I_exc_ecall,
   input  logic        I_mret,
   input  logic        I_irq_ext,
   input  logic        I_irq_timer,
   input  logic        I_csr_we,
   input  logic [11:0] I_csr_addr,
   input  logic [31:0] I_csr_wdata,
   output logic [31:0] O_csr_rdata,
   output logic        O_priv_en,
   output logic        O_priv_sel,
   output logic [31:0] O_mtvec,
   output logic [31:0] O_mepc,
   output logic        O_flush,
   output logic        O_busy
);
   typedef enum logic [1:0] {IDLE, TRAP, RET} state_t;
   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   state_t      state, state_nxt;
   logic        m_ie, m_pie, m_eie, m_tie;
   logic [31:0] mtvec, mepc, mcause, cause;
   logic        idle_v, irq_e, irq_t, trap, ret, csr_wr;
   logic        unused_pc;
   assign unused_pc = ^I_pc[1:0];
   assign idle_v = (state == IDLE) && I_valid;
   assign irq_e  = I_irq_ext & m_eie & m_ie;
   assign irq_t  = I_irq_timer & m_tie & m_ie;
   assign trap   = idle_v & (I_exc_illegal | I_exc_ecall | irq_e | irq_t);
   assign ret    = idle_v & I_mret & ~trap;
   assign csr_wr = idle_v & I_csr_we & ~trap & ~ret;
   assign cause  = I_exc_illegal ? 32'h0000_0002 :
                   I_exc_ecall   ? 32'h0000_000B :
                   irq_e         ? 32'h8000_000B : 32'h8000_0007;
   // TRAP and RET last one cycle: trap/ret are only ever true in IDLE
   always_comb begin
      state_nxt = trap ? TRAP : ret ? RET : IDLE;
   end
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) state <= IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         m_ie   <= 1'b0;
         m_pie  <= 1'b0;
         m_eie  <= 1'b0;
         m_tie  <= 1'b0;
         mtvec  <= {MTVEC_RESET[31:2], 2'b00};
         mepc   <= 32'h0;
         mcause <= 32'h0;
      end else if (trap) begin
         mepc   <= {I_pc[31:2], 2'b00};
         mcause <= cause;
         m_pie  <= m_ie;
         m_ie   <= 1'b0;
      end else if (ret) begin
         m_ie   <= m_pie;
         m_pie  <= 1'b1;
      end else if (csr_wr) begin
         case (I_csr_addr)
            A_MSTATUS: begin
               m_ie  <= I_csr_wdata[3];
               m_pie <= I_csr_wdata[7];
            end
            A_MIE: begin
               m_tie <= I_csr_wdata[7];
               m_eie <= I_csr_wdata[11];
            end
            A_MTVEC:  mtvec  <= {I_csr_wdata[31:2], 2'b00};
            A_MEPC:   mepc   <= {I_csr_wdata[31:2], 2'b00};
            A_MCAUSE: mcause <= I_csr_wdata;
            default: ;
         endcase
      end
   end
   always_comb begin
      O_csr_rdata = 32'h0;
      case (I_csr_addr)
         A_MSTATUS: O_csr_rdata = {24'h0, m_pie, 3'b000, m_ie, 3'b000};
         A_MIE:     O_csr_rdata = {20'h0, m_eie, 3'b000, m_tie, 7'h00};
         A_MTVEC:   O_csr_rdata = mtvec;
         A_MEPC:    O_csr_rdata = mepc;
         A_MCAUSE:  O_csr_rdata = mcause;
         default:   O_csr_rdata = 32'h0;
      endcase
   end
   assign O_priv_en  = state != IDLE;
   assign O_priv_sel = state == RET;
   assign O_flush    = state != IDLE;
   assign O_busy     = state != IDLE;
   assign O_mtvec    = mtvec;
   assign O_mepc     = mepc;
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed checks of trap priority, CSR side effects, FSM timing and async reset.
module tb_trap_controller;
   localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
   logic        I_clk = 1'b0;
   logic        I_rst;
   logic        I_valid, I_exc_illegal, I_exc_ecall, I_mret, I_irq_ext, I_irq_timer, I_csr_we;
   logic [31:0] I_pc, I_csr_wdata;
   logic [11:0] I_csr_addr;
   logic [31:0] O_csr_rdata, O_mtvec, O_mepc;
   logic        O_priv_en, O_priv_sel, O_flush, O_busy;
   int          n_run = 0;
   int          n_fail = 0;
   logic [31:0] r;

   trap_controller #(.MTVEC_RESET(MTVEC_RST)) dut (
      .I_clk(I_clk), .I_rst(I_rst), .I_valid(I_valid), .I_pc(I_pc),
      .I_exc_illegal(I_exc_illegal), .I_exc_ecall(I_exc_ecall), .I_mret(I_mret),
      .I_irq_ext(I_irq_ext), .I_irq_timer(I_irq_timer), .I_csr_we(I_csr_we),
      .I_csr_addr(I_csr_addr), .I_csr_wdata(I_csr_wdata), .O_csr_rdata(O_csr_rdata),
      .O_priv_en(O_priv_en), .O_priv_sel(O_priv_sel), .O_mtvec(O_mtvec), .O_mepc(O_mepc),
      .O_flush(O_flush), .O_busy(O_busy)
   );

   always #5 I_clk = ~I_clk;

   // Inputs change and outputs are sampled around the falling edge, away from the active edge.
   task automatic clear_in();
      I_valid = 0; I_exc_illegal = 0; I_exc_ecall = 0; I_mret = 0;
      I_csr_we = 0; I_pc = 0; I_csr_wdata = 0;
   endtask

   task automatic step();
      @(negedge I_clk);
      clear_in();
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      I_csr_addr = a;
      #1 d = O_csr_rdata;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      I_valid = 1; I_csr_we = 1; I_csr_addr = a; I_csr_wdata = d;
      step();
   endtask

   task automatic test_reset();
      I_irq_ext = 0; I_irq_timer = 0; I_csr_addr = 0;
      clear_in();
      I_rst = 1;
      repeat (2) @(negedge I_clk);
      I_rst = 0;
      #1;
      n_run++;
      if ({O_priv_en, O_priv_sel, O_flush, O_busy} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ctrl got %b want 0000", {O_priv_en, O_priv_sel, O_flush, O_busy});
      end
      n_run++;
      if (O_mtvec !== 32'h0000_1000) begin n_fail++; $display("FAIL reset_mtvec got %h want 00001000", O_mtvec); end
      n_run++;
      if (O_mepc !== 32'h0) begin n_fail++; $display("FAIL reset_mepc got %h want 0", O_mepc); end
      rd(12'h300, r);
      n_run++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL reset_mstatus got %h want 0", r); end
      rd(12'h304, r);
      n_run++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL reset_mie got %h want 0", r); end
      rd(12'h342, r);
      n_run++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL reset_mcause got %h want 0", r); end
      rd(12'h123, r);
      n_run++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h want 0", r); end
   endtask

   task automatic test_illegal();
      @(negedge I_clk);
      wr(12'h305, 32'h100);
      wr(12'h300, 32'h8);
      I_valid = 1; I_exc_illegal = 1; I_pc = 32'h40;
      step();
      n_run++;
      if ({O_priv_en, O_priv_sel, O_flush, O_busy} !== 4'b1011) begin
         n_fail++; $display("FAIL illegal_ctrl got %b want 1011", {O_priv_en, O_priv_sel, O_flush, O_busy});
      end
      n_run++;
      if (O_mepc !== 32'h40 || O_mtvec !== 32'h100) begin
         n_fail++; $display("FAIL illegal_pcs got mepc=%h mtvec=%h want 40/100", O_mepc, O_mtvec);
      end
      rd(12'h342, r);
      n_run++;
      if (r !== 32'h2) begin n_fail++; $display("FAIL illegal_mcause got %h want 2", r); end
      rd(12'h300, r);
      n_run++;
      if (r !== 32'h80) begin n_fail++; $display("FAIL illegal_mstatus got %h want 80", r); end
      step();
      n_run++;
      if ({O_priv_en, O_flush, O_busy} !== 3'b000) begin
         n_fail++; $display("FAIL illegal_one_cycle got %b want 000", {O_priv_en, O_flush, O_busy});
      end
   endtask

   task automatic test_mret();
      I_valid = 1; I_mret = 1;
      step();
      n_run++;
      if ({O_priv_en, O_priv_sel, O_flush, O_busy} !== 4'b1111 || O_mepc !== 32'h40) begin
         n_fail++; $display("FAIL mret_ctrl got %b mepc=%h want 1111/40", {O_priv_en, O_priv_sel, O_flush, O_busy}, O_mepc);
      end
      rd(12'h300, r);
      n_run++;
      if (r !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus got %h want 88", r); end
      step();
      n_run++;
      if (O_priv_en !== 1'b0) begin n_fail++; $display("FAIL mret_one_cycle got %b want 0", O_priv_en); end
   endtask

   task automatic test_priority();
      wr(12'h304, 32'h880);
      I_irq_ext = 1; I_irq_timer = 1;
      I_valid = 1; I_exc_ecall = 1; I_pc = 32'h83;
      step();
      rd(12'h342, r);
      n_run++;
      if (r !== 32'hB || O_mepc !== 32'h80) begin
         n_fail++; $display("FAIL ecall_prio got mcause=%h mepc=%h want b/80", r, O_mepc);
      end
      step();
      I_valid = 1; I_mret = 1;
      step();
      n_run++;
      if (O_priv_sel !== 1'b1) begin n_fail++; $display("FAIL prio_mret got sel=%b want 1", O_priv_sel); end
      step();
      I_valid = 1; I_pc = 32'h90;
      step();
      rd(12'h342, r);
      n_run++;
      if (r !== 32'h8000_000B || O_priv_en !== 1'b1) begin
         n_fail++; $display("FAIL ext_irq got mcause=%h en=%b want 8000000b/1", r, O_priv_en);
      end
      I_irq_ext = 0; I_irq_timer = 0;
      step();
      I_valid = 1; I_mret = 1;
      step();
      step();
   endtask

   task automatic test_timer_masked();
      wr(12'h300, 32'h0);
      wr(12'h304, 32'h80);
      I_irq_timer = 1;
      for (int i = 0; i < 10; i++) begin
         I_valid = 1;
         step();
         n_run++;
         if (O_priv_en !== 1'b0) begin n_fail++; $display("FAIL timer_masked cyc%0d got en=%b want 0", i, O_priv_en); end
      end
      wr(12'h300, 32'h8);
      step();
      n_run++;
      if (O_priv_en !== 1'b0) begin n_fail++; $display("FAIL timer_no_valid got en=%b want 0", O_priv_en); end
      I_valid = 1; I_pc = 32'hA0;
      step();
      rd(12'h342, r);
      n_run++;
      if (r !== 32'h8000_0007 || O_priv_en !== 1'b1) begin
         n_fail++; $display("FAIL timer_irq got mcause=%h en=%b want 80000007/1", r, O_priv_en);
      end
      I_irq_timer = 0;
      step();
      I_valid = 1; I_mret = 1;
      step();
      step();
   endtask

   task automatic test_same_edge();
      I_valid = 1; I_exc_illegal = 1; I_pc = 32'h200;
      I_csr_we = 1; I_csr_addr = 12'h341; I_csr_wdata = 32'h1234;
      step();
      n_run++;
      if (O_mepc !== 32'h200) begin n_fail++; $display("FAIL same_edge_mepc got %h want 200", O_mepc); end
      step();
      I_valid = 1; I_mret = 1;
      step();
      step();
      wr(12'h341, 32'h1237);
      rd(12'h341, r);
      n_run++;
      if (r !== 32'h1234) begin n_fail++; $display("FAIL mepc_align got %h want 1234", r); end
   endtask

   task automatic test_async_reset();
      @(negedge I_clk);
      I_valid = 1; I_exc_illegal = 1; I_pc = 32'h300;
      step();
      n_run++;
      if (O_busy !== 1'b1) begin n_fail++; $display("FAIL pre_reset_trap got busy=%b want 1", O_busy); end
      #1 I_rst = 1;
      #1;
      n_run++;
      if ({O_priv_en, O_flush, O_busy} !== 3'b000) begin
         n_fail++; $display("FAIL async_reset_ctrl got %b want 000", {O_priv_en, O_flush, O_busy});
      end
      n_run++;
      if (O_mtvec !== 32'h1000 || O_mepc !== 32'h0) begin
         n_fail++; $display("FAIL async_reset_pcs got mtvec=%h mepc=%h want 1000/0", O_mtvec, O_mepc);
      end
      rd(12'h342, r);
      n_run++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL async_reset_mcause got %h want 0", r); end
      rd(12'h304, r);
      n_run++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL async_reset_mie got %h want 0", r); end
      @(negedge I_clk);
      I_rst = 0;
   endtask

   initial begin
      test_reset();
      test_illegal();
      test_mret();
      test_priority();
      test_timer_masked();
      test_same_edge();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/trap_controller.md
# trap_controller

Machine-mode trap and return sequencer for the RV32 core. Prioritises exceptions, interrupts and `mret`, and updates the trap CSRs: mstatus.MIE/MPIE, mie.MEIE/MTIE, mtvec, mepc and mcause. It drives the enable and select inputs of `mux_privilege`, which picks the next PC from sequential PC, trap vector or mepc, and asserts a one-cycle pipeline flush on every redirect.

## Interface
Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] are forced to 0 (direct mode only).

Ports:
- I_clk  in  1  clock; all state changes on the rising edge.
- I_rst  in  1  asynchronous, active-high reset.
- I_valid  in  1  an instruction is committing this cycle; all events are qualified by it.
- I_pc  in  32  PC of the committing instruction.
- I_exc_illegal  in  1  illegal-instruction exception.
- I_exc_ecall  in  1  ecall exception.
- I_mret  in  1  committing instruction is `mret`.
- I_irq_ext  in  1  external interrupt, level-sensitive.
- I_irq_timer  in  1  timer interrupt, level-sensitive.
- I_csr_we  in  1  CSR write strobe.
- I_csr_addr  in  12  CSR address for both read and write.
- I_csr_wdata  in  32  CSR write data.
- O_csr_rdata  out  32  combinational read data; 0 for unmapped addresses.
- O_priv_en  out  1  to `mux_privilege` I_en. 0 selects the sequential PC.
- O_priv_sel  out  1  to `mux_privilege` I_sel. With O_priv_en=1: 0 selects mtvec, 1 selects mepc.
- O_mtvec  out  32  drives `mux_privilege` I_data2.
- O_mepc  out  32  drives `mux_privilege` I_data3.
- O_flush  out  1  squash in-flight instructions.
- O_busy  out  1  high in TRAP/RET; the pipeline must not commit.

## Operation
CSR map:
- 0x300 mstatus: bit 3 is MIE, bit 7 is MPIE; all other bits read 0.
- 0x304 mie: bit 7 is MTIE, bit 11 is MEIE.
- 0x305 mtvec.
- 0x341 mepc: bits [1:0] are forced to 0 on every write.
- 0x342 mcause.

Event selection happens only in IDLE with I_valid=1. Fixed priority, highest first:
1. Illegal instruction: mcause = 32'h2.
2. ecall: mcause = 32'hB.
3. External interrupt, taken if I_irq_ext & MEIE & MIE: mcause = 32'h8000_000B.
4. Timer interrupt, taken if I_irq_timer & MTIE & MIE: mcause = 32'h8000_0007.
5. mret.

Trap taken (any of 1–4):
- mepc ← {I_pc[31:2], 2'b00}.
- mcause ← code from the list above.
- MPIE ← MIE, MIE ← 0.
- State → TRAP.

mret taken: MIE ← MPIE, MPIE ← 1, state → RET.

CSR writes:
- Applied on the edge where I_csr_we=1 and state is IDLE.
- If a trap or mret is taken on the same edge, the CSR write is dropped entirely.
- Writes during TRAP/RET are ignored.

FSM:
- IDLE → TRAP on trap; IDLE → RET on mret; otherwise stay in IDLE.
- TRAP → IDLE unconditionally. RET → IDLE unconditionally.
- Any event or CSR write presented in TRAP/RET is ignored. Interrupts are level-sensitive, so a still-asserted interrupt is re-evaluated in IDLE.

Outputs by state:
- IDLE: en=0, sel=0, flush=0, busy=0.
- TRAP: en=1, sel=0, flush=1, busy=1.
- RET: en=1, sel=1, flush=1, busy=1.
- Outputs are registered-state decodes with no combinational path from event inputs.

## Timing
- Event sampled at edge N. CSR updates are visible from N. The redirect (en/flush) is high for exactly the cycle between edges N and N+1. IDLE is regained at N+1, so a new event is accepted at edge N+2 at the earliest.
- O_mepc and O_mtvec are stable throughout the TRAP/RET cycle; mepc is written at edge N, before the mux uses it.
- O_csr_rdata reflects updates on the cycle after the edge that made them.
- Reset values: state IDLE; all outputs 0 except O_mtvec = MTVEC_RESET with bits [1:0] cleared; MIE, MPIE, MEIE, MTIE, mepc and mcause all 0.
- Reset asserted mid-TRAP or mid-RET: all state and outputs return to reset values immediately, with no clock needed; the redirect is abandoned.
- I_valid=0 suppresses every event, including a pending interrupt, and suppresses CSR writes.

## Test plan
- After reset, write mtvec=0x100 and set MIE=1. Commit with illegal=1, pc=0x40 → next cycle en=1, sel=0, flush=1 for one cycle; mepc=0x40, mcause=2, MIE=0, MPIE=1.
- From that trapped state, commit with mret=1 → next cycle en=1, sel=1, O_mepc=0x40; afterwards MIE=1, MPIE=1.
- MIE=1, MEIE=1, MTIE=1, both interrupt lines high, ecall=1, pc=0x80 → mcause=0xB. After the following mret, the external interrupt wins with mcause=0x8000_000B.
- MIE=0, MTIE=1, irq_timer=1 for 10 cycles → en stays 0. Write mstatus=0x8 → trap with mcause=0x8000_0007.
- Same edge: csr_we to mepc with data 0x1234 plus illegal at pc=0x200 → mepc=0x200 and the write is dropped. Separately, a write of 0x1237 to mepc reads back 0x1234.
- Assert I_rst during the TRAP cycle → en, flush and busy drop immediately; all CSRs reset; O_mtvec = MTVEC_RESET.
